// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of the two-port memory arbiter.
// The arbiter uses the slave view; the requesters/memory model use the master view.
interface mem_arbiter_if #(
    parameter int p_WORD_LEN = 16,
    parameter int p_ADDR_LEN = 10
);
    logic                  i_req0, i_req1;
    logic                  i_lock0, i_lock1;
    logic                  i_wr_en0, i_wr_en1;
    logic [15:0]           i_addr0, i_addr1;
    logic [p_WORD_LEN-1:0] i_wr_data0, i_wr_data1;
    logic                  o_gnt0, o_gnt1;
    logic                  o_rd_valid0, o_rd_valid1;
    logic [p_WORD_LEN-1:0] o_rd_data;
    logic [p_ADDR_LEN-1:0] o_mem_addr;
    logic                  o_mem_wr_en;
    logic [p_WORD_LEN-1:0] o_mem_wr_data;
    logic [p_WORD_LEN-1:0] i_mem_rd_data;

    modport slave (
        input  i_req0, i_req1, i_lock0, i_lock1, i_wr_en0, i_wr_en1,
        input  i_addr0, i_addr1, i_wr_data0, i_wr_data1, i_mem_rd_data,
        output o_gnt0, o_gnt1, o_rd_valid0, o_rd_valid1, o_rd_data,
        output o_mem_addr, o_mem_wr_en, o_mem_wr_data
    );

    modport master (
        output i_req0, i_req1, i_lock0, i_lock1, i_wr_en0, i_wr_en1,
        output i_addr0, i_addr1, i_wr_data0, i_wr_data1, i_mem_rd_data,
        input  o_gnt0, o_gnt1, o_rd_valid0, o_rd_valid1, o_rd_data,
        input  o_mem_addr, o_mem_wr_en, o_mem_wr_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter: combinational round-robin grant with
// lock hold, out-of-range write suppression and a one-cycle registered read return.
module mem_arbiter #(
    parameter int p_WORD_LEN = 16,
    parameter int p_ADDR_LEN = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    mem_arbiter_if.slave  bus
);
    logic       last_q, last_d;
    logic       hold_q, hold_d;
    logic       pend_q, pend_d;
    logic       owner_q, owner_d;
    logic       oob_q, oob_d;

    logic [1:0]            req, lock;
    logic                  hold, gnt_any, gidx, sel_wr, in_range;
    logic [15:0]           sel_addr;
    logic [p_WORD_LEN-1:0] sel_wd;

    always_comb begin
        req      = {bus.i_req1, bus.i_req0};
        lock     = {bus.i_lock1, bus.i_lock0};
        // The previous grantee keeps the bus only while it still requests and locks.
        hold     = hold_q && req[last_q] && lock[last_q];
        gnt_any  = (|req) && !i_rst;
        if (hold)          gidx = last_q;
        else if (&req)     gidx = ~last_q;
        else if (req[1])   gidx = 1'b1;
        else               gidx = 1'b0;

        sel_addr = gidx ? bus.i_addr1    : bus.i_addr0;
        sel_wd   = gidx ? bus.i_wr_data1 : bus.i_wr_data0;
        sel_wr   = gidx ? bus.i_wr_en1   : bus.i_wr_en0;
        in_range = 32'(sel_addr) < (32'd1 << p_ADDR_LEN);

        last_d   = gnt_any ? gidx : last_q;
        hold_d   = gnt_any && lock[gidx];
        pend_d   = gnt_any && !sel_wr;
        owner_d  = gidx;
        oob_d    = !in_range;

        bus.o_gnt0        = gnt_any && !gidx;
        bus.o_gnt1        = gnt_any && gidx;
        bus.o_mem_addr    = sel_addr[p_ADDR_LEN-1:0];
        bus.o_mem_wr_data = sel_wd;
        bus.o_mem_wr_en   = gnt_any && sel_wr && in_range;

        bus.o_rd_valid0   = pend_q && !owner_q;
        bus.o_rd_valid1   = pend_q && owner_q;
        // Out-of-range reads return zero rather than aliased memory contents.
        bus.o_rd_data     = (pend_q && !oob_q) ? bus.i_mem_rd_data : '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_q  <= 1'b1;
            hold_q  <= 1'b0;
            pend_q  <= 1'b0;
            owner_q <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            last_q  <= last_d;
            hold_q  <= hold_d;
            pend_q  <= pend_d;
            owner_q <= owner_d;
            oob_q   <= oob_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected read returns are queued at grant time
// and compared when the arbiter signals rd_valid.
module tb_mem_arbiter;
    localparam int WL = 16;
    localparam int AL = 10;

    typedef struct packed {
        logic        req;
        logic        lock;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wd;
    } rq_t;

    typedef struct {
        logic        own;
        logic [15:0] data;
        int          due;
    } ret_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    ret_t q[$];
    logic [15:0] ref_mem [0:(1<<AL)-1];
    logic [15:0] mem     [0:(1<<AL)-1];
    logic [15:0] mem_rd_q;

    mem_arbiter_if #(.p_WORD_LEN(WL), .p_ADDR_LEN(AL)) bus ();
    mem_arbiter #(.p_WORD_LEN(WL), .p_ADDR_LEN(AL)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Synchronous memory: read data one cycle after the address.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < (1 << AL); i++) mem[i] <= 16'h0000;
            mem[0] <= 16'h0BAD; mem[1] <= 16'h1111; mem[2] <= 16'h2222;
            mem[3] <= 16'h3333; mem[4] <= 16'h4444; mem[16'h21] <= 16'hBEEF;
        end else if (bus.o_mem_wr_en) begin
            mem[bus.o_mem_addr] <= bus.o_mem_wr_data;
        end
        mem_rd_q <= mem[bus.o_mem_addr];
    end
    assign bus.i_mem_rd_data = mem_rd_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic rq_t idle();
        return '0;
    endfunction

    function automatic rq_t rd(input logic [15:0] a);
        rq_t r = '0;
        r.req = 1'b1; r.addr = a;
        return r;
    endfunction

    function automatic rq_t wrq(input logic [15:0] a, input logic [15:0] d, input logic lk);
        rq_t r = '0;
        r.req = 1'b1; r.wr = 1'b1; r.addr = a; r.wd = d; r.lock = lk;
        return r;
    endfunction

    task automatic drive(input rq_t a, input rq_t b);
        bus.i_req0 = a.req; bus.i_lock0 = a.lock; bus.i_wr_en0 = a.wr;
        bus.i_addr0 = a.addr; bus.i_wr_data0 = a.wd;
        bus.i_req1 = b.req; bus.i_lock1 = b.lock; bus.i_wr_en1 = b.wr;
        bus.i_addr1 = b.addr; bus.i_wr_data1 = b.wd;
    endtask

    task automatic check_ret();
        ret_t e;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("rd_valid0", 32'(bus.o_rd_valid0), 32'(!e.own));
            chk("rd_valid1", 32'(bus.o_rd_valid1), 32'(e.own));
            chk("rd_data",   32'(bus.o_rd_data),   32'(e.data));
        end else begin
            chk("no_valid", 32'({bus.o_rd_valid1, bus.o_rd_valid0}), 32'd0);
            chk("idle_rd_data", 32'(bus.o_rd_data), 32'd0);
        end
    endtask

    // One bus cycle: drive after the edge, check grant, return and memory side mid-cycle.
    task automatic step(input rq_t a, input rq_t b, input logic [1:0] eg);
        rq_t g;
        logic inr;
        ret_t e;
        @(posedge clk); #1;
        drive(a, b);
        @(negedge clk);
        chk("gnt0", 32'(bus.o_gnt0), 32'(eg[0]));
        chk("gnt1", 32'(bus.o_gnt1), 32'(eg[1]));
        check_ret();
        if (eg != 2'b00) begin
            g = eg[1] ? b : a;
            inr = g.addr < 16'(1 << AL);
            chk("mem_wr_en", 32'(bus.o_mem_wr_en), 32'(g.wr && inr));
            if (inr) chk("mem_addr", 32'(bus.o_mem_addr), 32'(g.addr[AL-1:0]));
            if (g.wr && inr) begin
                chk("mem_wr_data", 32'(bus.o_mem_wr_data), 32'(g.wd));
                ref_mem[g.addr[AL-1:0]] = g.wd;
            end
            if (!g.wr) begin
                e.own = eg[1];
                e.data = inr ? ref_mem[g.addr[AL-1:0]] : 16'h0000;
                e.due = cyc + 1;
                q.push_back(e);
            end
        end else begin
            chk("mem_wr_en_idle", 32'(bus.o_mem_wr_en), 32'd0);
        end
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < (1 << AL); i++) ref_mem[i] = 16'h0000;
        ref_mem[0] = 16'h0BAD; ref_mem[1] = 16'h1111; ref_mem[2] = 16'h2222;
        ref_mem[3] = 16'h3333; ref_mem[4] = 16'h4444; ref_mem[16'h21] = 16'hBEEF;

        // Reset state with live requests: everything stays quiet.
        drive(wrq(16'h0021, 16'hDEAD, 1'b1), rd(16'h0002));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0", 32'(bus.o_gnt0), 32'd0);
        chk("rst_gnt1", 32'(bus.o_gnt1), 32'd0);
        chk("rst_wr_en", 32'(bus.o_mem_wr_en), 32'd0);
        chk("rst_valid", 32'({bus.o_rd_valid1, bus.o_rd_valid0}), 32'd0);
        chk("rst_rd_data", 32'(bus.o_rd_data), 32'd0);
        drive(idle(), idle());
        preload = 1'b0;
        rst = 1'b0;

        // Single read, 1-cycle latency.
        step(rd(16'h0021), idle(), 2'b01);
        // Lone req1 write leaves r_last = 1 for the round-robin run.
        step(idle(), wrq(16'h0005, 16'h5555, 1'b0), 2'b10);
        // Continuous contention alternates 0,1,0,1 with back-to-back returns.
        step(rd(16'h0003), rd(16'h0004), 2'b01);
        step(rd(16'h0003), rd(16'h0004), 2'b10);
        step(rd(16'h0003), rd(16'h0005), 2'b01);
        step(rd(16'h0003), rd(16'h0005), 2'b10);
        // r_last = 1 so requester 0 wins next.
        step(rd(16'h0001), rd(16'h0002), 2'b01);
        // Locked writer holds the bus for 3 cycles against requester 0.
        step(rd(16'h0010), wrq(16'h0010, 16'h1234, 1'b1), 2'b10);
        step(rd(16'h0010), wrq(16'h0010, 16'h1234, 1'b1), 2'b10);
        step(rd(16'h0010), wrq(16'h0010, 16'h1234, 1'b1), 2'b10);
        step(rd(16'h0010), idle(), 2'b01);
        // Out-of-range write is granted but not performed; out-of-range read returns 0.
        step(wrq(16'h0400, 16'hAAAA, 1'b0), idle(), 2'b01);
        step(rd(16'h0400), idle(), 2'b01);
        step(rd(16'h0000), idle(), 2'b01);
        // Alternating owners on consecutive cycles.
        step(rd(16'h0001), idle(), 2'b01);
        step(idle(), rd(16'h0002), 2'b10);
        step(rd(16'h0005), idle(), 2'b01);
        // Write by one requester while the other's read returns.
        step(idle(), wrq(16'h0007, 16'h7777, 1'b0), 2'b10);
        step(idle(), rd(16'h0007), 2'b10);
        step(idle(), idle(), 2'b00);

        // Reset mid-cycle while a read return is being presented.
        step(rd(16'h0021), idle(), 2'b01);
        @(posedge clk); #1;
        drive(idle(), idle());
        #2;
        check_ret();
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'({bus.o_rd_valid1, bus.o_rd_valid0}), 32'd0);
        chk("midrst_rd_data", 32'(bus.o_rd_data), 32'd0);
        q.delete();
        cyc++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(idle(), idle(), 2'b00);
        // Reset restores r_last = 1: requester 0 wins the first contention.
        step(rd(16'h0002), rd(16'h0001), 2'b01);
        step(idle(), idle(), 2'b00);

        if (q.size() != 0) chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
